// File: rtl/seq_scan_pkg.sv
// Shared definitions for the sequence-scan arbiter.
//   state_t : FSM states (IDLE -> CLEAR -> SHIFT -> WAIT -> DONE)
//   BCD_68  : the two-digit BCD code word "68" the detector looks for
package seq_scan_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CLEAR = 3'd1,
    SHIFT = 3'd2,
    WAIT  = 3'd3,
    DONE  = 3'd4
  } state_t;

  localparam logic [7:0] BCD_68 = 8'h68;

endpackage

// File: rtl/seq_scan_arbiter_rr_pick.sv
// Combinational round-robin selector.
// Ports:
//   i_req    : per-requester request bits
//   i_ptr    : index of the most recently served requester
//   o_onehot : one-hot winner (all zero when no request)
//   o_idx    : index of the winner
//   o_valid  : at least one request present
module rr_pick #(
  parameter int N_REQ = 4,
  parameter int PTR_W = 2
) (
  input  logic [N_REQ-1:0] i_req,
  input  logic [PTR_W-1:0] i_ptr,
  output logic [N_REQ-1:0] o_onehot,
  output logic [PTR_W-1:0] o_idx,
  output logic             o_valid
);

  logic             w_found;
  logic [PTR_W-1:0] w_cand;

  // Search starts one past the last winner and wraps, so the last winner
  // has the lowest priority.
  always_comb begin
    o_onehot = '0;
    o_idx    = '0;
    w_found  = 1'b0;
    w_cand   = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      w_cand = PTR_W'((int'(i_ptr) + k) % N_REQ);
      if (!w_found && i_req[w_cand]) begin
        w_found          = 1'b1;
        o_idx            = w_cand;
        o_onehot[w_cand] = 1'b1;
      end
    end
  end

  assign o_valid = |i_req;

endmodule

// File: rtl/seq_scan_arbiter.sv
// Shares one serial BCD sequence detector among N_REQ requesters.
// A granted requester's word is shifted MSB-first into the detector after a
// one-cycle detector clear; the detector's match output is sampled over the
// shift and a short trailing window, and the result is returned with a
// one-cycle done pulse to that requester.
// Ports:
//   i_clk, i_rst_n : clock (rising edge), asynchronous active-low reset
//   i_req          : per-requester level request
//   i_data         : packed code words, requester i at [i*W +: W]
//   o_gnt          : one-hot grant held for the whole transaction
//   o_done         : one-cycle pulse to the granted requester
//   o_match        : result, valid only while o_done is non-zero
//   o_busy         : high whenever not idle
//   o_det_clear    : detector clear
//   o_det_din      : detector serial input
//   i_det_dout     : detector registered match output
module seq_scan_arbiter
  import seq_scan_pkg::*;
#(
  parameter int N_REQ     = 4,
  parameter int W         = 8,
  parameter int MATCH_WIN = 2
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic [N_REQ-1:0]   i_req,
  input  logic [N_REQ*W-1:0] i_data,
  output logic [N_REQ-1:0]   o_gnt,
  output logic [N_REQ-1:0]   o_done,
  output logic               o_match,
  output logic               o_busy,
  output logic               o_det_clear,
  output logic               o_det_din,
  input  logic               i_det_dout
);

  localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int CNT_W = $clog2(W + 1);
  localparam int WIN_W = $clog2(MATCH_WIN + 1);

  state_t           r_state;
  logic [PTR_W-1:0] r_ptr;
  logic [N_REQ-1:0] r_gnt;
  logic [W-1:0]     r_shift;
  logic [CNT_W-1:0] r_bitCnt;
  logic [WIN_W-1:0] r_winCnt;
  logic             r_sticky;

  logic [N_REQ-1:0] w_pickOneHot;
  logic [PTR_W-1:0] w_pickIdx;
  logic             w_pickValid;

  rr_pick #(
    .N_REQ (N_REQ),
    .PTR_W (PTR_W)
  ) u_rr_pick (
    .i_req    (i_req),
    .i_ptr    (r_ptr),
    .o_onehot (w_pickOneHot),
    .o_idx    (w_pickIdx),
    .o_valid  (w_pickValid)
  );

  // Transaction FSM. The word is captured at the grant edge so later data
  // changes cannot disturb it, and req is not looked at again until IDLE.
  // The detector output is Moore and registered, so the first SHIFT cycle
  // still shows the cleared state and is skipped; every later SHIFT cycle
  // and every WAIT cycle reflects a state reached after a shifted bit.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state  <= IDLE;
      r_ptr    <= PTR_W'(N_REQ - 1);
      r_gnt    <= '0;
      r_shift  <= '0;
      r_bitCnt <= '0;
      r_winCnt <= '0;
      r_sticky <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_pickValid) begin
            r_state <= CLEAR;
            r_gnt   <= w_pickOneHot;
            r_shift <= i_data[w_pickIdx*W +: W];
            r_ptr   <= w_pickIdx;
          end
        end
        CLEAR: begin
          r_sticky <= 1'b0;
          r_bitCnt <= '0;
          r_state  <= SHIFT;
        end
        SHIFT: begin
          r_shift <= r_shift << 1;
          if (r_bitCnt != '0) begin
            r_sticky <= r_sticky | i_det_dout;
          end
          if (r_bitCnt == CNT_W'(W - 1)) begin
            r_winCnt <= '0;
            r_state  <= WAIT;
          end else begin
            r_bitCnt <= r_bitCnt + CNT_W'(1);
          end
        end
        WAIT: begin
          r_sticky <= r_sticky | i_det_dout;
          if (r_winCnt == WIN_W'(MATCH_WIN - 1)) begin
            r_state <= DONE;
          end else begin
            r_winCnt <= r_winCnt + WIN_W'(1);
          end
        end
        DONE: begin
          r_gnt   <= '0;
          r_state <= IDLE;
        end
        default: begin
          r_gnt   <= '0;
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign o_gnt       = r_gnt;
  assign o_done      = (r_state == DONE) ? r_gnt : '0;
  assign o_match     = (r_state == DONE) && r_sticky;
  assign o_busy      = (r_state != IDLE);
  assign o_det_clear = (r_state == CLEAR);
  assign o_det_din   = (r_state == SHIFT) && r_shift[W-1];

endmodule

// File: tb/tb_seq_scan_arbiter.sv
// Self-checking bench for seq_scan_arbiter with a behavioural BCD "68"
// detector attached and a queue-based round-robin reference model.
module tb_seq_scan_arbiter;
  import seq_scan_pkg::*;

  localparam int N  = 4;
  localparam int W  = 8;
  localparam int MW = 2;
  localparam int LAT = 1 + W + MW;

  logic           clk = 1'b0;
  logic           rstN;
  logic [N-1:0]   req;
  logic [N*W-1:0] data;
  logic [N-1:0]   gnt;
  logic [N-1:0]   done;
  logic           match;
  logic           busy;
  logic           detClear;
  logic           detDin;
  logic           detDout;
  logic [7:0]     detHist = '0;

  int checkCount = 0;
  int passCount  = 0;
  int rrOrder[$];

  seq_scan_arbiter #(
    .N_REQ     (N),
    .W         (W),
    .MATCH_WIN (MW)
  ) dut (
    .i_clk       (clk),
    .i_rst_n     (rstN),
    .i_req       (req),
    .i_data      (data),
    .o_gnt       (gnt),
    .o_done      (done),
    .o_match     (match),
    .o_busy      (busy),
    .o_det_clear (detClear),
    .o_det_din   (detDin),
    .i_det_dout  (detDout)
  );

  // Clock generation, 10 time-unit period.
  always #5 clk = ~clk;

  // Stand-in for the shared detector: remembers the last eight serial bits
  // and flags a registered match when they spell BCD 68.
  always @(posedge clk) begin
    if (detClear) detHist <= '0;
    else          detHist <= {detHist[6:0], detDin};
  end
  assign detDout = (detHist == BCD_68);

  // Safety net so the run always ends.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checkCount++;
    assert (obs === exp) passCount++;
    else $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Reference round robin: a priority list where the served requester
  // moves to the back.
  function automatic void modelReset();
    rrOrder = {};
    for (int i = 0; i < N; i++) rrOrder.push_back(i);
  endfunction

  function automatic int modelPick(input logic [N-1:0] r);
    for (int j = 0; j < rrOrder.size(); j++)
      if (r[rrOrder[j]]) return rrOrder[j];
    return -1;
  endfunction

  function automatic void modelServe(input int w);
    int x;
    do begin
      x = rrOrder.pop_front();
      rrOrder.push_back(x);
    end while (x != w);
  endfunction

  // The detector sees the word MSB-first followed by zeros; a match is any
  // sampled window whose last eight bits read 68. Sampled windows are the
  // ones reached after 1 .. W+MW-1 bits.
  function automatic logic modelMatch(input logic [W-1:0] word);
    logic bits [W+MW];
    logic [7:0] win;
    for (int i = 0; i < W + MW; i++) bits[i] = (i < W) ? word[W-1-i] : 1'b0;
    for (int m = 1; m < W + MW; m++) begin
      win = '0;
      for (int j = 0; j < m; j++) win = {win[6:0], bits[j]};
      if (win == BCD_68) return 1'b1;
    end
    return 1'b0;
  endfunction

  // One full transaction, entered and left on a falling edge while idle.
  task automatic applyStimulus(input logic [N-1:0] reqV, input logic [N*W-1:0] dataV,
                               input int modAt, input logic [N-1:0] modReq,
                               input logic [N*W-1:0] modData, input bit checkStream);
    int expWin;
    logic [N-1:0] expGnt;
    logic [W-1:0] expWord;
    logic [W-1:0] stream;
    logic gntHeld;
    int doneAt;
    req  = reqV;
    data = dataV;
    expWin = modelPick(reqV);
    if (expWin < 0) return;
    expGnt  = '0;
    expGnt[expWin] = 1'b1;
    expWord = dataV[expWin*W +: W];
    checkOutput("idleBusy", {31'b0, busy}, 0);
    @(negedge clk);
    checkOutput("grant", {28'b0, gnt}, {28'b0, expGnt});
    checkOutput("detClear", {31'b0, detClear}, 1);
    stream  = '0;
    gntHeld = 1'b1;
    doneAt  = -1;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (k == modAt) begin
        req  = modReq;
        data = modData;
      end
      if (k <= W) stream = {stream[W-2:0], detDin};
      if (gnt !== expGnt) gntHeld = 1'b0;
      if (done != '0) begin
        doneAt = k;
        break;
      end
    end
    checkOutput("doneLatency", doneAt, LAT);
    checkOutput("doneOneHot", {28'b0, done}, {28'b0, expGnt});
    checkOutput("match", {31'b0, match}, {31'b0, modelMatch(expWord)});
    checkOutput("gntHeld", {31'b0, gntHeld}, 1);
    if (checkStream) checkOutput("dinStream", {24'b0, stream}, {24'b0, expWord});
    @(negedge clk);
    checkOutput("postBusy", {31'b0, busy}, 0);
    checkOutput("postGnt", {28'b0, gnt}, 0);
    modelServe(expWin);
  endtask

  function automatic logic [W-1:0] pickWord();
    case ($urandom_range(0, 3))
      0:       return 8'h68;
      1:       return 8'h34;
      2:       return 8'hB4;
      default: return W'($urandom);
    endcase
  endfunction

  // Directed scenarios first, then randomized traffic.
  initial begin
    logic [N*W-1:0] d;
    logic [N*W-1:0] d2;
    logic [N-1:0] r;
    int doneSeen;
    rstN = 1'b0;
    req  = '0;
    data = '0;
    modelReset();
    repeat (3) @(negedge clk);
    checkOutput("rstGnt", {28'b0, gnt}, 0);
    checkOutput("rstBusy", {31'b0, busy}, 0);
    checkOutput("rstDetClear", {31'b0, detClear}, 0);
    checkOutput("rstDetDin", {31'b0, detDin}, 0);
    rstN = 1'b1;
    @(negedge clk);

    $display("[TB] contention and pointer wrap");
    d = {8'h11, 8'h68, 8'h34, 8'h68};
    for (int t = 0; t < 4; t++) applyStimulus(4'b1111, d, -1, '0, '0, 1'b0);
    applyStimulus(4'b1001, d, -1, '0, '0, 1'b0);

    $display("[TB] single request with match and no match");
    applyStimulus(4'b0001, {24'h0, 8'h68}, -1, '0, '0, 1'b1);
    applyStimulus(4'b0100, {8'h0, 8'h69, 16'h0}, -1, '0, '0, 1'b1);

    $display("[TB] request drop and data change");
    d  = {16'h0, 8'h68, 8'h0};
    d2 = {16'h0, 8'h55, 8'h0};
    applyStimulus(4'b0010, d, 3, 4'b0000, d2, 1'b1);

    $display("[TB] reset during shift");
    req  = 4'b0001;
    data = {24'h0, 8'h68};
    @(negedge clk);
    for (int k = 1; k <= 5; k++) @(negedge clk);
    rstN = 1'b0;
    #1;
    checkOutput("abortGnt", {28'b0, gnt}, 0);
    checkOutput("abortBusy", {31'b0, busy}, 0);
    checkOutput("abortDetDin", {31'b0, detDin}, 0);
    req = '0;
    modelReset();
    doneSeen = 0;
    repeat (2) @(negedge clk);
    rstN = 1'b1;
    for (int k = 0; k < 15; k++) begin
      @(negedge clk);
      if (done != '0) doneSeen++;
    end
    checkOutput("abortNoDone", doneSeen, 0);
    applyStimulus(4'b0010, {16'h0, 8'h68, 8'h0}, -1, '0, '0, 1'b0);
    applyStimulus(4'b0011, {16'h0, 8'h69, 8'h68}, -1, '0, '0, 1'b0);

    $display("[TB] randomized traffic");
    for (int t = 0; t < 20; t++) begin
      r = N'($urandom_range(1, (1 << N) - 1));
      for (int i = 0; i < N; i++) d[i*W +: W] = pickWord();
      for (int i = 0; i < N; i++) d2[i*W +: W] = W'($urandom);
      if ($urandom_range(0, 2) == 0)
        applyStimulus(r, d, $urandom_range(1, 9), N'($urandom), d2, 1'b1);
      else
        applyStimulus(r, d, -1, '0, '0, 1'b1);
    end

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule

// File: doc/seq_scan_arbiter.md
Name: seq_scan_arbiter

Overview:
- Shares one serial BCD sequence detector among N_REQ requesters.
- Each requester presents a W-bit code word. The block grants requesters round-robin, clears the detector, and shifts the granted word MSB-first onto the detector's serial input.
- It then samples the detector's match output over a window and returns a per-requester done pulse with a match flag.
- It sits between the requester logic and the single detector instance.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- W, 8, code word width in bits; 8 bits = two BCD digits.
- MATCH_WIN, 2, cycles after the last shifted bit during which det_dout is still sampled (1..7).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- req  in  N_REQ  per-requester request; level, held until that requester's done.
- data  in  N_REQ*W  packed code words; requester i occupies bits [i*W +: W].
- gnt  out  N_REQ  one-hot grant, held for the entire transaction.
- done  out  N_REQ  one-cycle pulse to the granted requester at transaction end.
- match  out  1  result, valid only while any done bit is high.
- busy  out  1  high in every state except IDLE.
- det_clear  out  1  one-cycle active-high clear to the detector.
- det_din  out  1  serial bit to the detector.
- det_dout  in  1  detector match output; Moore output, registered.

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE.
  - gnt, done, match, busy, det_clear and det_din all 0.
  - RR pointer = N_REQ-1, so requester 0 has first priority.
  - Shift register, bit counter and sticky flag cleared.
  - Reset mid-transaction aborts it; no done is issued.
- States: IDLE -> CLEAR -> SHIFT -> WAIT -> DONE -> IDLE.
- IDLE:
  - If any req bit is set, pick the first requester at or after ptr+1 (modulo N_REQ).
  - On the next edge: go to CLEAR, set gnt one-hot, latch that requester's word into the shift register, set ptr = winner.
- CLEAR (1 cycle):
  - det_clear=1, det_din=0, sticky flag cleared.
- SHIFT (W cycles):
  - det_din = shift register MSB.
  - Shift left once per cycle; the bit counter counts 0..W-1.
- WAIT (MATCH_WIN cycles):
  - det_din=0.
- Match sampling:
  - Sticky flag |= det_dout in every SHIFT cycle after the first, and in every WAIT cycle.
  - Sampling therefore covers detector states reached after each shifted bit.
- DONE (1 cycle):
  - done[winner]=1 and match=sticky flag.
  - gnt is still asserted, then drops on return to IDLE.
- Latency:
  - IDLE->CLEAR at edge E.
  - done is high in the cycle beginning at E + 1 + W + MATCH_WIN.
  - W=8, MATCH_WIN=2: done high 11 cycles after the grant edge.
- Back-to-back:
  - At least one IDLE cycle separates transactions.
  - Requests are re-arbitrated there with the updated ptr.
- Request and data handling:
  - req dropped mid-transaction is ignored; the transaction completes and done still pulses.
  - data changes after the grant edge are ignored.
- Simultaneous requests: strict round-robin; no requester waits more than N_REQ-1 transactions.
- det_dout high during CLEAR is ignored.
- Unreachable state encodings return to IDLE.

Decomposition:
- Package seq_scan_pkg holds:
  - the state enum (IDLE, CLEAR, SHIFT, WAIT, DONE), logic [2:0];
  - the BCD_68 constant 8'h68, used by the bench.
- One sub-module, rr_pick:
  - combinational round-robin selector;
  - inputs req and ptr, outputs a one-hot winner and its index.
- The FSM, shift register and counters stay in seq_scan_arbiter.

Test Plan:
- Single request, match: req=4'b0001, data[7:0]=8'h68, real detector attached -> gnt=0001 for 12 cycles; done[0] pulses exactly 11 cycles after the grant edge with match=1; det_din serial stream is 0,1,1,0,1,0,0,0.
- Single request, no match: req[2] with data 8'h69 -> done[2] pulses with match=0; busy falls the following cycle.
- Contention: req=4'b1111 held -> grant order 0,1,2,3,0; each done one-hot and matching the grant; one IDLE cycle between transactions.
- Pointer wrap: after requester 3 is served, req=4'b1001 -> requester 0 is granted next, not 3.
- Reset mid-SHIFT: reset low at bit 4 -> all outputs 0 immediately and no done; after release, req[1] is granted first only if req[0]=0.
- Req drop and data change: req[1] falls and data[1] changes during SHIFT -> original word still shifted out and done[1] pulses.
